// File: rtl/v2f_mul_seq_accum.sv
// Purpose     : iterative WIDTH x WIDTH multiplier (result mod 2^WIDTH) built from 16x16 limb products,
//               issuing one partial product per cycle into a full-width accumulator.
// Latency     : N cycles from the input handshake to out_valid (N=10 for WIDTH=64, N=3 for WIDTH=32).
// Backpressure: in_ready is high only while idle; y/out_valid are held until out_ready; no overlap.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b sampled when both high)
//   a, b                WIDTH-bit operands; signedness is irrelevant to the low WIDTH bits
//   out_valid/out_ready result handshake
//   y                   a*b mod 2^WIDTH; keeps its last value until the next result completes
module v2f_mul_seq_accum #(
    parameter int WIDTH  = 64,
    parameter int LIMB_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam int L = WIDTH / LIMB_W;
    localparam int N = L * (L + 1) / 2;

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("v2f_mul_seq_accum: WIDTH must be 32 or 64");
    end
    if (LIMB_W != 16) begin : g_bad_limb
        $error("v2f_mul_seq_accum: LIMB_W must be 16");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [3:0]          idx;
    // (row, col) walk the product order: ascending column, then ascending row within it.
    // The B limb index is col - row, so only terms with i+j < L are ever produced.
    logic [1:0]          col;
    logic [1:0]          row;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    y_reg;

    logic [1:0]          bsel;
    logic [LIMB_W-1:0]   a_limb;
    logic [LIMB_W-1:0]   b_limb;
    logic [2*LIMB_W-1:0] pp;
    logic [WIDTH-1:0]    term;
    logic [WIDTH-1:0]    sum;
    logic                last;

    always_comb begin
        bsel   = col - row;
        a_limb = a_reg[LIMB_W*row +: LIMB_W];
        b_limb = b_reg[LIMB_W*bsel +: LIMB_W];
        // Zero-extended unsigned limb product; never sign-extended.
        pp     = (2*LIMB_W)'(a_limb) * (2*LIMB_W)'(b_limb);
        // Bits pushed past WIDTH-1 by the column shift are simply lost (mod 2^WIDTH).
        term   = WIDTH'(pp) << (LIMB_W * int'(col));
        sum    = acc + term;
        last   = (idx == 4'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            col   <= '0;
            row   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            y_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        idx   <= '0;
                        col   <= '0;
                        row   <= '0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc <= sum;
                    idx <= idx + 4'd1;
                    if (row == col) begin
                        col <= col + 2'd1;
                        row <= '0;
                    end else begin
                        row <= row + 2'd1;
                    end
                    // y is a separate register so it stays put while the next product accumulates.
                    if (last) begin
                        y_reg <= sum;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign y         = y_reg;

endmodule
